// File: rtl/bus_arbiter_split_if.sv
// Bus arbiter signal bundle: master requests and transfer pulses in,
// grant/ownership status out. The arbiter connects through the slave modport.
interface bus_arbiter_split_if #(
    parameter int NUM_MASTERS = 4,
    parameter int SLAVE_LEN   = 2
);
    logic [NUM_MASTERS-1:0]           request;
    logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel;
    logic                             trans_done;
    logic                             split;
    logic                             split_resume;
    logic [NUM_MASTERS-1:0]           grant;
    logic [SLAVE_LEN-1:0]             grant_slave;
    logic                             arbiter_busy;
    logic                             bus_busy;
    logic [NUM_MASTERS-1:0]           split_pending;

    modport master (
        output request, slave_sel, trans_done, split, split_resume,
        input  grant, grant_slave, arbiter_busy, bus_busy, split_pending
    );

    modport slave (
        input  request, slave_sel, trans_done, split, split_resume,
        output grant, grant_slave, arbiter_busy, bus_busy, split_pending
    );
endinterface

// File: rtl/bus_arbiter_split.sv
// N-master bus arbiter with one outstanding split transaction.
// IDLE -> ARB (one cycle, arbiter_busy) -> OWN (grant held until the owner
// completes, is split, or abandons). A parked master whose slave has signalled
// resume wins the next arbitration ahead of everyone else.
module bus_arbiter_split #(
    parameter int NUM_MASTERS = 4,
    parameter int SLAVE_LEN   = 2,
    parameter int RR_MODE     = 1
) (
    input logic                i_clk,
    input logic                i_reset,
    bus_arbiter_split_if.slave io_bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ARB, OWN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [SLAVE_LEN-1:0]   r_grant_slave, w_grant_slave_nxt;
    logic                   r_arb_busy, w_arb_busy_nxt;
    logic                   r_bus_busy, w_bus_busy_nxt;
    logic [NUM_MASTERS-1:0] r_split_pending, w_split_pending_nxt;
    logic [SLAVE_LEN-1:0]   r_split_slave, w_split_slave_nxt;
    logic                   r_resume, w_resume_nxt;
    logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]       r_owner, w_owner_nxt;
    logic [IDX_W-1:0]       r_park_idx, w_park_idx_nxt;

    logic [NUM_MASTERS-1:0] w_elig;
    logic                   w_park_win;
    logic                   w_pick_vld;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [IDX_W-1:0]       w_scan_idx;
    logic                   w_exit;

    // Eligibility: requesting, not parked, and not targeting the split slave
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_elig[i] = io_bus.request[i] && !r_split_pending[i] &&
                        !((r_split_pending != '0) &&
                          (io_bus.slave_sel[i*SLAVE_LEN +: SLAVE_LEN] == r_split_slave));
        end
        w_park_win = r_resume && ((io_bus.request & r_split_pending) != '0);
    end

    // Winner search: resumed parked master first, else fixed or rotating priority
    always_comb begin
        int j;
        j          = 0;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_scan_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = (RR_MODE != 0) ? (int'(r_ptr) + 1 + k) : k;
            if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            w_scan_idx = IDX_W'(j);
            if (!w_pick_vld && w_elig[w_scan_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_scan_idx;
            end
        end
        if (w_park_win) begin
            w_pick_vld = 1'b1;
            w_pick_idx = r_park_idx;
        end
    end

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        w_state_nxt         = r_state;
        w_grant_nxt         = r_grant;
        w_grant_slave_nxt   = r_grant_slave;
        w_arb_busy_nxt      = 1'b0;
        w_bus_busy_nxt      = r_bus_busy;
        w_split_pending_nxt = r_split_pending;
        w_split_slave_nxt   = r_split_slave;
        w_resume_nxt        = r_resume;
        w_ptr_nxt           = r_ptr;
        w_owner_nxt         = r_owner;
        w_park_idx_nxt      = r_park_idx;
        w_exit              = 1'b0;

        // Resume only means something while a master is parked
        if (io_bus.split_resume && (r_split_pending != '0)) w_resume_nxt = 1'b1;

        case (r_state)
            IDLE: begin
                w_grant_nxt    = '0;
                w_bus_busy_nxt = 1'b0;
                if ((w_elig != '0) || w_park_win) begin
                    w_state_nxt    = ARB;
                    w_arb_busy_nxt = 1'b1;
                end
            end
            ARB: begin
                if (w_pick_vld) begin
                    w_state_nxt       = OWN;
                    w_grant_nxt       = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_pick_idx;
                    w_grant_slave_nxt = io_bus.slave_sel[w_pick_idx*SLAVE_LEN +: SLAVE_LEN];
                    w_bus_busy_nxt    = 1'b1;
                    w_owner_nxt       = w_pick_idx;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OWN: begin
                // trans_done takes precedence over a simultaneous split
                if (io_bus.trans_done) begin
                    w_exit = 1'b1;
                    if (r_split_pending[r_owner]) begin
                        w_split_pending_nxt = '0;
                        w_resume_nxt        = 1'b0;
                    end
                end else if (io_bus.split && (r_split_pending == '0)) begin
                    w_exit              = 1'b1;
                    w_split_pending_nxt = r_grant;
                    w_split_slave_nxt   = r_grant_slave;
                    w_park_idx_nxt      = r_owner;
                end else if (!io_bus.request[r_owner]) begin
                    w_exit = 1'b1;
                end
                if (w_exit) begin
                    w_state_nxt    = IDLE;
                    w_grant_nxt    = '0;
                    w_bus_busy_nxt = 1'b0;
                    w_ptr_nxt      = r_owner;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_grant_nxt    = '0;
                w_bus_busy_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any parked transfer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_grant         <= '0;
            r_grant_slave   <= '0;
            r_arb_busy      <= 1'b0;
            r_bus_busy      <= 1'b0;
            r_split_pending <= '0;
            r_split_slave   <= '0;
            r_resume        <= 1'b0;
            r_ptr           <= IDX_W'(NUM_MASTERS - 1);
            r_owner         <= '0;
            r_park_idx      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_grant         <= w_grant_nxt;
            r_grant_slave   <= w_grant_slave_nxt;
            r_arb_busy      <= w_arb_busy_nxt;
            r_bus_busy      <= w_bus_busy_nxt;
            r_split_pending <= w_split_pending_nxt;
            r_split_slave   <= w_split_slave_nxt;
            r_resume        <= w_resume_nxt;
            r_ptr           <= w_ptr_nxt;
            r_owner         <= w_owner_nxt;
            r_park_idx      <= w_park_idx_nxt;
        end
    end

    assign io_bus.grant         = r_grant;
    assign io_bus.grant_slave   = r_grant_slave;
    assign io_bus.arbiter_busy  = r_arb_busy;
    assign io_bus.bus_busy      = r_bus_busy;
    assign io_bus.split_pending = r_split_pending;
endmodule
